pll_dyn_cfg_ctrl: RTL

Run-time reconfiguration sequencer for a GTP_PLL_E3-class PLL wrapper with dynamic ratio/duty enabled. It holds the live divider/duty set, validates and accepts new sets over a valid/ready handshake, and sequences PLL reset, lock wait, lock filtering and bounded retry. It also monitors lock loss. It sits between system control logic and the PLL wrapper's RATIO*/DUTY*/RST/LOCK pins.

---
 rtl/pll_dyn_cfg_if.sv | 15 +
 rtl/pll_dyn_cfg_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pll_dyn_cfg_if.sv
// pll_dyn_cfg_if: configuration handshake between system control and the PLL reconfiguration sequencer.
interface pll_dyn_cfg_if #(
   parameter int NUM_OUT = 3,
   parameter int DIV_W   = 10
);
   logic                     cfg_valid;
   logic                     cfg_ready;
   logic [DIV_W-1:0]         cfg_idiv;
   logic [DIV_W-1:0]         cfg_fdiv;
   logic [NUM_OUT*DIV_W-1:0] cfg_odiv;
   logic [NUM_OUT*DIV_W-1:0] cfg_duty;
   logic                     cfg_err;
   modport master (output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, output cfg_ready, cfg_err);
endinterface

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: holds live PLL divider/duty set, validates new sets, sequences reset, lock wait, filtering and retry.
module pll_dyn_cfg_ctrl #(
   parameter int                       NUM_OUT      = 3,
   parameter int                       DIV_W        = 10,
   parameter logic [DIV_W-1:0]         DEF_IDIV     = 5,
   parameter logic [DIV_W-1:0]         DEF_FDIV     = 91,
   parameter logic [NUM_OUT*DIV_W-1:0] DEF_ODIV     = {10'd7, 10'd26, 10'd14},
   parameter logic [NUM_OUT*DIV_W-1:0] DEF_DUTY     = {10'd7, 10'd26, 10'd14},
   parameter int                       RST_CYCLES   = 16,
   parameter int                       LOCK_TIMEOUT = 65535,
   parameter int                       LOCK_FILTER  = 8,
   parameter int                       MAX_RETRY    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   pll_dyn_cfg_if.slave             cfg,
   input  logic                     pll_lock_in,
   output logic                     pll_rst_out,
   output logic [DIV_W-1:0]         pll_idiv,
   output logic [DIV_W-1:0]         pll_fdiv,
   output logic [NUM_OUT*DIV_W-1:0] pll_odiv,
   output logic [NUM_OUT*DIV_W-1:0] pll_duty,
   output logic                     locked,
   output logic                     busy,
   output logic                     fail,
   output logic                     lock_lost,
   output logic [1:0]               retry_cnt
);
   localparam int CW = $clog2((LOCK_TIMEOUT > RST_CYCLES ? LOCK_TIMEOUT : RST_CYCLES) + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   typedef enum logic [1:0] {RST_ASSERT, WAIT_LOCK, IDLE, FAIL} state_t;
   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [FW-1:0]    filt, filt_n;
   logic [1:0]       retry_n;
   logic             lost_n, err_q, xfer, ok;
   logic [DIV_W-1:0] od, du;
   assign pll_rst_out   = state == RST_ASSERT || state == FAIL;
   assign busy          = state == RST_ASSERT || state == WAIT_LOCK;
   assign locked        = state == IDLE;
   assign fail          = state == FAIL;
   assign cfg.cfg_ready = state == IDLE || state == FAIL;
   assign cfg.cfg_err   = err_q;
   assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
   // duty <= 2*odiv-1 is checked as duty < 2*odiv with one extra bit of headroom
   always_comb begin
      od = '0;
      du = '0;
      ok = |cfg.cfg_idiv && |cfg.cfg_fdiv;
      for (int i = 0; i < NUM_OUT; i++) begin
         od = cfg.cfg_odiv[i*DIV_W +: DIV_W];
         du = cfg.cfg_duty[i*DIV_W +: DIV_W];
         ok = ok && |od && |du && ({1'b0, du} < {od, 1'b0});
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      filt_n  = filt;
      retry_n = retry_cnt;
      lost_n  = lock_lost;
      case (state)
         RST_ASSERT: begin
            cnt_n   = cnt == CW'(RST_CYCLES - 1) ? '0 : cnt + CW'(1);
            filt_n  = '0;
            state_n = cnt == CW'(RST_CYCLES - 1) ? WAIT_LOCK : RST_ASSERT;
         end
         WAIT_LOCK: begin
            cnt_n  = cnt + CW'(1);
            filt_n = pll_lock_in ? filt + FW'(1) : '0;
            if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               cnt_n   = '0;
               retry_n = int'(retry_cnt) < MAX_RETRY ? retry_cnt + 2'd1 : retry_cnt;
               state_n = int'(retry_cnt) < MAX_RETRY ? RST_ASSERT : FAIL;
            end else if (pll_lock_in && filt == FW'(LOCK_FILTER - 1)) begin
               state_n = IDLE;
            end
         end
         IDLE: if (!pll_lock_in) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
            filt_n  = '0;
            retry_n = '0;
            lost_n  = 1'b1;
         end
         default: ;
      endcase
      // an accepted valid set overrides whatever IDLE/FAIL decided this cycle
      if (xfer && ok) begin
         state_n = RST_ASSERT;
         cnt_n   = '0;
         filt_n  = '0;
         retry_n = '0;
         lost_n  = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_ASSERT;
         cnt       <= '0;
         filt      <= '0;
         retry_cnt <= '0;
         lock_lost <= 1'b0;
         err_q     <= 1'b0;
         pll_idiv  <= DEF_IDIV;
         pll_fdiv  <= DEF_FDIV;
         pll_odiv  <= DEF_ODIV;
         pll_duty  <= DEF_DUTY;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         filt      <= filt_n;
         retry_cnt <= retry_n;
         lock_lost <= lost_n;
         err_q     <= xfer && !ok;
         if (xfer && ok) begin
            pll_idiv <= cfg.cfg_idiv;
            pll_fdiv <= cfg.cfg_fdiv;
            pll_odiv <= cfg.cfg_odiv;
            pll_duty <= cfg.cfg_duty;
         end
      end
   end
endmodule
